spi_flash_prog_seq: RTL and testbench
=====================================

// Module: spi_flash_prog_seq
// PURPOSE
//  Sequences spi_master_fl for flash write/erase. One upstream request becomes WREN (0x06),
//  then PROGRAM (0x02) or SECTOR ERASE (0x20), then RDSR (0x05) polling until WIP (SR bit0)=0.
//  Sits between the CPU/register front-end and spi_master_fl. Drives that block's command port.
// PARAMETERS
//  POLL_GAP    16     idle clk cycles between consecutive RDSR polls (>=1)
//  POLL_MAX    65535  max RDSR polls before timeout (16-bit counter)
//  CT_CMD      3'd0   commtype: command only
//  CT_CMD_RX   3'd1   commtype: command + read answer
//  CT_ADDR_TX  3'd2   commtype: command + address + data tx
//  CT_ADDR     3'd3   commtype: command + address
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-low reset (0 = reset)
//  req_valid    in   1   upstream request valid
//  req_ready    out  1   high in IDLE; request accepted on req_valid&&req_ready
//  req_op       in   1   0 = page program, 1 = sector erase
//  req_addr     in   32  flash address
//  req_data     in   32  program data (ignored for erase)
//  req_nbits    in   7   program data bits: 8/16/24/32; other values are coerced to 32
//  req_4byte    in   1   4-byte address mode
//  done         out  1   1-cycle pulse at end of sequence
//  err_timeout  out  1   valid with done: POLL_MAX reached with WIP still 1
//  m_valid      out  1   -> spi_master_fl validflag
//  m_tready     in   1   <- spi_master_fl tready
//  m_command    out  8   -> command
//  m_commtype   out  3   -> commtype
//  m_address    out  32  -> address
//  m_data_in    out  32  -> data_in
//  m_ndata_bits out  7   -> ndata_bits
//  m_4byte      out  1   -> fourbyteaddr_on
//  m_data_out   in   32  <- data_out (valid when m_tready rises)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, req_ready=1, done=0, err_timeout=0, m_valid=0,
//   m_command=0, m_commtype=CT_CMD, m_address=0, m_data_in=0, m_ndata_bits=7'd8, m_4byte=0.
//   Also clears counters and latched request. Reset mid-sequence aborts it. No done pulse is given.
//  Accept: in IDLE with req_valid=1, latch op/addr/data/nbits/4byte. Set req_ready=0 next cycle.
//  Master transaction (ISSUE->START->WAIT) for every command:
//   ISSUE: drive m_* fields and m_valid=1. Hold them until m_valid&&m_tready (accept).
//    m_valid drops the cycle after accept.
//   START: wait for m_tready=0 (master busy).
//   WAIT: wait for m_tready=1 (transfer done, m_data_out valid that cycle).
//  FSM: IDLE -> WREN(ISSUE/START/WAIT) -> OP(ISSUE/START/WAIT) -> POLL(ISSUE/START/WAIT)
//   WREN:  cmd 0x06, CT_CMD.
//   OP program: cmd 0x02, CT_ADDR_TX, m_data_in=req_data, m_ndata_bits=req_nbits.
//   OP erase:   cmd 0x20, CT_ADDR.
//   POLL:  cmd 0x05, CT_CMD_RX, ndata_bits=8. Sample m_data_out[0] on POLL WAIT exit. Then poll_cnt++.
//    bit0=0 -> DONE.
//    bit0=1 and poll_cnt==POLL_MAX -> DONE with err_timeout=1.
//    bit0=1 otherwise -> GAP.
//   GAP: count POLL_GAP cycles, then -> POLL ISSUE.
//   DONE: done=1 for 1 cycle, err_timeout valid with it. Next cycle -> IDLE, req_ready=1.
//  poll_cnt is cleared on accept. It saturates and never wraps.
//  m_address = req_addr. With m_4byte=0 the master uses only bits [23:0].
//  Latency floor: done comes no earlier than 1 cycle after the last POLL WAIT exit.
//  m_tready already 0 in ISSUE: keep m_valid=1 until the master accepts. No request is dropped.
//  req_valid while busy is ignored (req_ready=0). err_timeout clears on the next accept.
// TESTING
//  1 Program: addr=0x001000, data=0xA5A5A5A5, nbits=32; model answers SR=0x00 once
//    -> WREN 0x06, then 0x02/CT_ADDR_TX/0x001000, then one 0x05 poll; done=1, err_timeout=0.
//  2 Erase: op=1, addr=0x020000; SR=0x01 x3 then 0x00
//    -> 0x20/CT_ADDR issued, 4 polls, each gap >=POLL_GAP cycles, done with err_timeout=0.
//  3 Timeout (POLL_MAX=4): SR stuck at 0x03 -> exactly 4 polls; done=1, err_timeout=1.
//  4 Backpressure: hold m_tready=0 5 cycles in ISSUE -> m_valid and fields stable, 1 accept only.
//  5 rst=0 during OP WAIT -> next cycle all outputs at reset values, req_ready=1, no done pulse.
//  6 req_valid held during the sequence -> ignored; second request accepted only after done.

Source files
------------

// File: rtl/spi_flash_prog_seq.sv
// rtl/spi_flash_prog_seq.sv - WREN / PROGRAM|ERASE / RDSR-poll sequencer driving spi_master_fl
module spi_flash_prog_seq #(
    parameter int         POLL_GAP   = 16,
    parameter int         POLL_MAX   = 65535,
    parameter logic [2:0] CT_CMD     = 3'd0,
    parameter logic [2:0] CT_CMD_RX  = 3'd1,
    parameter logic [2:0] CT_ADDR_TX = 3'd2,
    parameter logic [2:0] CT_ADDR    = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [6:0]  req_nbits,
    input  logic        req_4byte,
    output logic        done,
    output logic        err_timeout,
    output logic        m_valid,
    input  logic        m_tready,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [6:0]  m_ndata_bits,
    output logic        m_4byte,
    input  logic [31:0] m_data_out
);

    localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_START, S_WAIT, S_GAP, S_DONE} state_t;
    typedef enum logic [1:0] {PH_WREN, PH_OP, PH_POLL} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [6:0]  nbits_q, nbits_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_command_q, m_command_d;
    logic [2:0]  m_commtype_q, m_commtype_d;
    logic [31:0] m_address_q, m_address_d;
    logic [31:0] m_data_in_q, m_data_in_d;
    logic [6:0]  m_ndata_bits_q, m_ndata_bits_d;
    logic        m_4byte_q, m_4byte_d;
    logic [6:0]  nbits_in;
    logic [15:0] poll_inc;
    logic        unused_sr_bits;

    assign unused_sr_bits = ^m_data_out[31:1];

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        op_d           = op_q;
        data_d         = data_q;
        nbits_d        = nbits_q;
        poll_cnt_d     = poll_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        req_ready_d    = req_ready_q;
        done_d         = 1'b0;
        err_d          = err_q;
        m_valid_d      = m_valid_q;
        m_command_d    = m_command_q;
        m_commtype_d   = m_commtype_q;
        m_address_d    = m_address_q;
        m_data_in_d    = m_data_in_q;
        m_ndata_bits_d = m_ndata_bits_q;
        m_4byte_d      = m_4byte_q;
        poll_inc       = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

        case (req_nbits)
            7'd8, 7'd16, 7'd24, 7'd32: nbits_in = req_nbits;
            default:                   nbits_in = 7'd32;
        endcase

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    op_d           = req_op;
                    data_d         = req_data;
                    nbits_d        = nbits_in;
                    m_address_d    = req_addr;
                    m_4byte_d      = req_4byte;
                    poll_cnt_d     = 16'd0;
                    err_d          = 1'b0;
                    req_ready_d    = 1'b0;
                    phase_d        = PH_WREN;
                    m_command_d    = 8'h06;
                    m_commtype_d   = CT_CMD;
                    m_ndata_bits_d = 7'd8;
                    m_valid_d      = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_tready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (!m_tready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_tready) begin
                    case (phase_q)
                        PH_WREN: begin
                            phase_d        = PH_OP;
                            m_command_d    = op_q ? 8'h20 : 8'h02;
                            m_commtype_d   = op_q ? CT_ADDR : CT_ADDR_TX;
                            m_data_in_d    = op_q ? m_data_in_q : data_q;
                            m_ndata_bits_d = op_q ? 7'd8 : nbits_q;
                            m_valid_d      = 1'b1;
                            state_d        = S_ISSUE;
                        end
                        PH_OP: begin
                            phase_d        = PH_POLL;
                            m_command_d    = 8'h05;
                            m_commtype_d   = CT_CMD_RX;
                            m_ndata_bits_d = 7'd8;
                            m_valid_d      = 1'b1;
                            state_d        = S_ISSUE;
                        end
                        default: begin
                            // Status byte is only valid in the cycle tready returns high
                            poll_cnt_d = poll_inc;
                            if (!m_data_out[0]) begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end else if (poll_inc == POLL_LIMIT) begin
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                gap_cnt_d = 16'd0;
                                state_d   = S_GAP;
                            end
                        end
                    endcase
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    m_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            phase_q        <= PH_WREN;
            op_q           <= 1'b0;
            data_q         <= 32'd0;
            nbits_q        <= 7'd8;
            poll_cnt_q     <= 16'd0;
            gap_cnt_q      <= 16'd0;
            req_ready_q    <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            m_valid_q      <= 1'b0;
            m_command_q    <= 8'h00;
            m_commtype_q   <= CT_CMD;
            m_address_q    <= 32'd0;
            m_data_in_q    <= 32'd0;
            m_ndata_bits_q <= 7'd8;
            m_4byte_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            op_q           <= op_d;
            data_q         <= data_d;
            nbits_q        <= nbits_d;
            poll_cnt_q     <= poll_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            req_ready_q    <= req_ready_d;
            done_q         <= done_d;
            err_q          <= err_d;
            m_valid_q      <= m_valid_d;
            m_command_q    <= m_command_d;
            m_commtype_q   <= m_commtype_d;
            m_address_q    <= m_address_d;
            m_data_in_q    <= m_data_in_d;
            m_ndata_bits_q <= m_ndata_bits_d;
            m_4byte_q      <= m_4byte_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign m_valid      = m_valid_q;
    assign m_command    = m_command_q;
    assign m_commtype   = m_commtype_q;
    assign m_address    = m_address_q;
    assign m_data_in    = m_data_in_q;
    assign m_ndata_bits = m_ndata_bits_q;
    assign m_4byte      = m_4byte_q;

endmodule

// File: tb/tb_spi_flash_prog_seq.sv
// tb/tb_spi_flash_prog_seq.sv - directed bench for spi_flash_prog_seq with a behavioural SPI master
module tb_spi_flash_prog_seq;

    localparam int POLL_GAP = 5;
    localparam int POLL_MAX = 4;
    localparam int BUSY     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [6:0]  req_nbits;
    logic        req_4byte;
    logic        done;
    logic        err_timeout;
    logic        m_valid;
    logic        m_tready;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [31:0] m_address;
    logic [31:0] m_data_in;
    logic [6:0]  m_ndata_bits;
    logic        m_4byte;
    logic [31:0] m_data_out;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [7:0]  lg_cmd[$];
    logic [2:0]  lg_type[$];
    logic [31:0] lg_addr[$];
    logic [31:0] lg_data[$];
    logic [6:0]  lg_nbits[$];
    logic        lg_4b[$];
    time         poll_acc_t[$];
    time         poll_rdy_t[$];
    logic [31:0] sr_q[$];
    logic [31:0] sr_default = 32'h0;
    bit          stall = 1'b0;

    spi_flash_prog_seq #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_nbits(req_nbits),
        .req_4byte(req_4byte), .done(done), .err_timeout(err_timeout),
        .m_valid(m_valid), .m_tready(m_tready), .m_command(m_command),
        .m_commtype(m_commtype), .m_address(m_address), .m_data_in(m_data_in),
        .m_ndata_bits(m_ndata_bits), .m_4byte(m_4byte), .m_data_out(m_data_out)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Master: accept when idle and not stalled, busy BUSY cycles, then ready with status
    initial begin
        logic [7:0] cur;
        m_tready   = 1'b1;
        m_data_out = 32'h0;
        forever begin
            @(negedge clk);
            m_tready = !stall;
            if (m_valid && m_tready) begin
                cur = m_command;
                lg_cmd.push_back(m_command);
                lg_type.push_back(m_commtype);
                lg_addr.push_back(m_address);
                lg_data.push_back(m_data_in);
                lg_nbits.push_back(m_ndata_bits);
                lg_4b.push_back(m_4byte);
                if (cur == 8'h05) poll_acc_t.push_back($time);
                @(negedge clk);
                m_tready = 1'b0;
                repeat (BUSY - 1) @(negedge clk);
                if (cur == 8'h05) begin
                    if (sr_q.size() > 0) m_data_out = sr_q.pop_front();
                    else m_data_out = sr_default;
                    poll_rdy_t.push_back($time);
                end else begin
                    m_data_out = 32'h0;
                end
                m_tready = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        lg_cmd.delete(); lg_type.delete(); lg_addr.delete(); lg_data.delete();
        lg_nbits.delete(); lg_4b.delete(); poll_acc_t.delete(); poll_rdy_t.delete();
        sr_q.delete();
    endtask

    task automatic start_req(input logic op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [6:0] nbits, input logic fb);
        bit acc = 1'b0;
        req_op = op; req_addr = addr; req_data = data; req_nbits = nbits; req_4byte = fb;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("req_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(output logic err, output time t);
        bit seen = 1'b0;
        err = 1'bx;
        t = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                err = err_timeout;
                t = $time;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        logic e;
        time  td;
        int   dc0;
        int   n_wren;
        rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = 32'h0;
        req_data = 32'h0; req_nbits = 7'd8; req_4byte = 1'b0;
        repeat (3) tick();

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_command", 32'(m_command), 32'h00);
        chk("rst_m_commtype", 32'(m_commtype), 32'd0);
        chk("rst_m_address", m_address, 32'h0);
        chk("rst_m_data_in", m_data_in, 32'h0);
        chk("rst_m_ndata_bits", 32'(m_ndata_bits), 32'd8);
        chk("rst_m_4byte", 32'(m_4byte), 32'd0);
        rst = 1'b1;
        tick();

        // 1: page program, single clean poll
        clear_log();
        sr_q.push_back(32'h00);
        start_req(1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 7'd32, 1'b0);
        chk("t1_req_ready_low", 32'(req_ready), 32'd0);
        wait_done(e, td);
        chk("t1_err", 32'(e), 32'd0);
        chk("t1_ncmd", 32'(lg_cmd.size()), 32'd3);
        chk("t1_wren_cmd", 32'(lg_cmd[0]), 32'h06);
        chk("t1_wren_type", 32'(lg_type[0]), 32'd0);
        chk("t1_pp_cmd", 32'(lg_cmd[1]), 32'h02);
        chk("t1_pp_type", 32'(lg_type[1]), 32'd2);
        chk("t1_pp_addr", lg_addr[1], 32'h0000_1000);
        chk("t1_pp_data", lg_data[1], 32'hA5A5_A5A5);
        chk("t1_pp_nbits", 32'(lg_nbits[1]), 32'd32);
        chk("t1_rdsr_cmd", 32'(lg_cmd[2]), 32'h05);
        chk("t1_rdsr_type", 32'(lg_type[2]), 32'd1);
        chk("t1_rdsr_nbits", 32'(lg_nbits[2]), 32'd8);
        chk("t1_latency", 32'((td - poll_rdy_t[0]) >= 10), 32'd1);
        tick();
        chk("t1_idle_ready", 32'(req_ready), 32'd1);
        chk("t1_done_1cyc", 32'(done), 32'd0);

        // 2: sector erase, WIP set for three polls
        clear_log();
        sr_q.push_back(32'h01); sr_q.push_back(32'h01);
        sr_q.push_back(32'h01); sr_q.push_back(32'h00);
        start_req(1'b1, 32'h0002_0000, 32'hDEAD_BEEF, 7'd8, 1'b0);
        wait_done(e, td);
        chk("t2_err", 32'(e), 32'd0);
        chk("t2_ncmd", 32'(lg_cmd.size()), 32'd6);
        chk("t2_se_cmd", 32'(lg_cmd[1]), 32'h20);
        chk("t2_se_type", 32'(lg_type[1]), 32'd3);
        chk("t2_se_addr", lg_addr[1], 32'h0002_0000);
        chk("t2_npoll", 32'(poll_acc_t.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2_gap%0d", i),
                32'((poll_acc_t[i] - poll_rdy_t[i-1]) >= 10 * (POLL_GAP + 1)), 32'd1);

        // 3: WIP stuck high until POLL_MAX polls
        clear_log();
        sr_default = 32'h03;
        start_req(1'b1, 32'h0003_0000, 32'h0, 7'd8, 1'b0);
        wait_done(e, td);
        sr_default = 32'h00;
        chk("t3_err", 32'(e), 32'd1);
        chk("t3_npoll", 32'(poll_acc_t.size()), 32'd4);
        tick();
        chk("t3_err_sticky", 32'(err_timeout), 32'd1);

        // 4: master backpressure in ISSUE, 4-byte address, odd nbits coerced
        clear_log();
        sr_q.push_back(32'h00);
        stall = 1'b1;
        start_req(1'b0, 32'h12AB_CDEF, 32'h0BAD_F00D, 7'd20, 1'b1);
        chk("t4_err_cleared", 32'(err_timeout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold_valid%0d", i), 32'(m_valid), 32'd1);
            chk($sformatf("t4_hold_cmd%0d", i), 32'(m_command), 32'h06);
            tick();
        end
        stall = 1'b0;
        wait_done(e, td);
        n_wren = 0;
        foreach (lg_cmd[i]) if (lg_cmd[i] == 8'h06) n_wren++;
        chk("t4_wren_once", 32'(n_wren), 32'd1);
        chk("t4_ncmd", 32'(lg_cmd.size()), 32'd3);
        chk("t4_addr32", lg_addr[1], 32'h12AB_CDEF);
        chk("t4_4byte", 32'(lg_4b[1]), 32'd1);
        chk("t4_nbits_coerce", 32'(lg_nbits[1]), 32'd32);

        // 5: reset while the OP command is in flight
        clear_log();
        sr_q.push_back(32'h00);
        start_req(1'b0, 32'h0000_4000, 32'h1234_5678, 7'd16, 1'b0);
        for (int i = 0; i < 100 && lg_cmd.size() < 2; i++) tick();
        chk("t5_op_issued", 32'(lg_cmd.size()), 32'd2);
        tick();
        tick();
        chk("t5_in_wait", 32'(m_valid), 32'd0);
        dc0 = done_cnt;
        rst = 1'b0;
        tick();
        chk("t5_req_ready", 32'(req_ready), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_err", 32'(err_timeout), 32'd0);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_m_command", 32'(m_command), 32'h00);
        chk("t5_m_commtype", 32'(m_commtype), 32'd0);
        chk("t5_m_address", m_address, 32'h0);
        chk("t5_m_data_in", m_data_in, 32'h0);
        chk("t5_m_ndata_bits", 32'(m_ndata_bits), 32'd8);
        chk("t5_m_4byte", 32'(m_4byte), 32'd0);
        rst = 1'b1;
        repeat (20) tick();
        chk("t5_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("t5_no_poll", 32'(lg_cmd.size()), 32'd2);

        // 6: req_valid held high across the whole sequence
        clear_log();
        sr_q.push_back(32'h00); sr_q.push_back(32'h00);
        dc0 = done_cnt;
        start_req(1'b0, 32'h0000_5000, 32'h0000_00C3, 7'd8, 1'b0);
        req_valid = 1'b1; req_addr = 32'h0000_6000; req_data = 32'h0000_C3C3; req_nbits = 7'd16;
        for (int i = 0; i < 2000 && done_cnt == dc0; i++) tick();
        chk("t6_first_seq_only", 32'(lg_cmd.size()), 32'd3);
        for (int i = 0; i < 200 && lg_cmd.size() < 4; i++) tick();
        req_valid = 1'b0;
        chk("t6_second_after_done", 32'(done_cnt - dc0), 32'd1);
        for (int i = 0; i < 2000 && done_cnt < dc0 + 2; i++) tick();
        chk("t6_ncmd", 32'(lg_cmd.size()), 32'd6);
        chk("t6_addr_a", lg_addr[1], 32'h0000_5000);
        chk("t6_nbits_a", 32'(lg_nbits[1]), 32'd8);
        chk("t6_wren_b", 32'(lg_cmd[3]), 32'h06);
        chk("t6_addr_b", lg_addr[4], 32'h0000_6000);
        chk("t6_data_b", lg_data[4], 32'h0000_C3C3);
        chk("t6_nbits_b", 32'(lg_nbits[4]), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
